// File: rtl/rv_cache_arb_pkg.sv
// rtl/rv_cache_arb_pkg.sv - shared types and constants for the cache bus arbiter
package rv_cache_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, DONE} arb_state_t;
    typedef enum logic {PORT_INS, PORT_DAT} arb_port_t;

    localparam logic [3:0] WSEL_ALL = 4'hF;

endpackage

// File: rtl/rv_cache_bus_arb_if.sv
// rtl/rv_cache_bus_arb_if.sv - cache-port and memory-bus signal bundle for rv_cache_bus_arb
interface rv_cache_bus_arb_if;

    logic        i_ins_read;
    logic [31:0] i_ins_addr;
    logic [31:0] o_ins_data;
    logic        o_ins_ack;
    logic        o_ins_err;

    logic        i_dat_read;
    logic        i_dat_write;
    logic [31:0] i_dat_addr;
    logic [3:0]  i_dat_wsel;
    logic [31:0] i_dat_wdata;
    logic [31:0] o_dat_data;
    logic        o_dat_ack;
    logic        o_dat_err;

    logic [31:0] o_bus_addr;
    logic        o_bus_read;
    logic        o_bus_write;
    logic [3:0]  o_bus_wsel;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_data;
    logic        i_bus_ack;

    modport slave (
        input  i_ins_read, i_ins_addr,
        output o_ins_data, o_ins_ack, o_ins_err,
        input  i_dat_read, i_dat_write, i_dat_addr, i_dat_wsel, i_dat_wdata,
        output o_dat_data, o_dat_ack, o_dat_err,
        output o_bus_addr, o_bus_read, o_bus_write, o_bus_wsel, o_bus_wdata,
        input  i_bus_data, i_bus_ack
    );

    modport master (
        output i_ins_read, i_ins_addr,
        input  o_ins_data, o_ins_ack, o_ins_err,
        output i_dat_read, i_dat_write, i_dat_addr, i_dat_wsel, i_dat_wdata,
        input  o_dat_data, o_dat_ack, o_dat_err,
        input  o_bus_addr, o_bus_read, o_bus_write, o_bus_wsel, o_bus_wdata,
        output i_bus_data, i_bus_ack
    );

endinterface

// File: rtl/rv_cache_bus_arb_rr2.sv
// rtl/rv_cache_bus_arb_rr2.sv - combinational 2-way round-robin pick between instr and data ports
module rv_arb_rr2
    import rv_cache_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_port_t  last_i,
    input  logic       prio_i,
    output arb_port_t  grant_o
);

    always_comb begin
        grant_o = last_i;
        case (req_i)
            2'b01:   grant_o = PORT_INS;
            2'b10:   grant_o = PORT_DAT;
            // tie: the port that did not win last time
            2'b11:   grant_o = (prio_i || last_i == PORT_INS) ? PORT_DAT : PORT_INS;
            default: grant_o = last_i;
        endcase
    end

endmodule

// File: rtl/rv_cache_bus_arb.sv
// rtl/rv_cache_bus_arb.sv - shares one memory bus between instr and data cache ports
// Optional performance counters under RV_CACHE_ARB_PERF_EN.
module rv_cache_bus_arb
    import rv_cache_arb_pkg::*;
#(
    parameter int PRIO_DATA   = 1,
    parameter int TIMEOUT_BIT = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    rv_cache_bus_arb_if.slave bus_if
`ifdef RV_CACHE_ARB_PERF_EN
    ,
    output logic [31:0]       o_perf_ins_grants,
    output logic [31:0]       o_perf_dat_grants,
    output logic [31:0]       o_perf_conflicts,
    output logic [31:0]       o_perf_timeouts
`endif
);

    // Last no-ack count before the timeout fires, giving 2**TIMEOUT_BIT-1 wait cycles.
    localparam logic [TIMEOUT_BIT-1:0] CNT_TMO = TIMEOUT_BIT'((2 ** TIMEOUT_BIT) - 2);

    arb_state_t             state_q, state_d;
    arb_port_t              last_q, last_d, grant;
    logic [TIMEOUT_BIT-1:0] cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]             wsel_q, wsel_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic                   ins_ack_q, ins_ack_d, ins_err_q, ins_err_d;
    logic                   dat_ack_q, dat_ack_d, dat_err_q, dat_err_d;
    logic [31:0]            ins_data_q, ins_data_d, dat_data_q, dat_data_d;
    logic [1:0]             req;
    logic                   tie_prio;
    logic                   timeout;

    assign req      = {bus_if.i_dat_read | bus_if.i_dat_write, bus_if.i_ins_read};
    assign tie_prio = (PRIO_DATA != 0) && (last_q == PORT_INS);

    rv_arb_rr2 u_rr2 (
        .req_i   (req),
        .last_i  (last_q),
        .prio_i  (tie_prio),
        .grant_o (grant)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wsel_d     = wsel_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ins_ack_d  = 1'b0;
        ins_err_d  = 1'b0;
        dat_ack_d  = 1'b0;
        dat_err_d  = 1'b0;
        ins_data_d = '0;
        dat_data_d = '0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    last_d = grant;
                    cnt_d  = '0;
                    if (grant == PORT_INS) begin
                        state_d = BUS_I;
                        addr_d  = bus_if.i_ins_addr;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                        wsel_d  = WSEL_ALL;
                        wdata_d = '0;
                    end else begin
                        state_d = BUS_D;
                        addr_d  = bus_if.i_dat_addr;
                        rd_d    = bus_if.i_dat_read;
                        wr_d    = bus_if.i_dat_write;
                        wsel_d  = bus_if.i_dat_write ? bus_if.i_dat_wsel : WSEL_ALL;
                        wdata_d = bus_if.i_dat_write ? bus_if.i_dat_wdata : '0;
                    end
                end
            end
            BUS_I, BUS_D: begin
                // ack beats a coincident timeout
                if (bus_if.i_bus_ack || cnt_q == CNT_TMO) begin
                    timeout = !bus_if.i_bus_ack;
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (state_q == BUS_I) begin
                        ins_ack_d  = 1'b1;
                        ins_err_d  = timeout;
                        ins_data_d = timeout ? '0 : bus_if.i_bus_data;
                    end else begin
                        dat_ack_d  = 1'b1;
                        dat_err_d  = timeout;
                        dat_data_d = (timeout || wr_q) ? '0 : bus_if.i_bus_data;
                    end
                end else begin
                    cnt_d = cnt_q + TIMEOUT_BIT'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            last_q     <= PORT_INS;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wsel_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ins_ack_q  <= 1'b0;
            ins_err_q  <= 1'b0;
            dat_ack_q  <= 1'b0;
            dat_err_q  <= 1'b0;
            ins_data_q <= '0;
            dat_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wsel_q     <= wsel_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ins_ack_q  <= ins_ack_d;
            ins_err_q  <= ins_err_d;
            dat_ack_q  <= dat_ack_d;
            dat_err_q  <= dat_err_d;
            ins_data_q <= ins_data_d;
            dat_data_q <= dat_data_d;
        end
    end

    assign bus_if.o_bus_addr  = addr_q;
    assign bus_if.o_bus_read  = rd_q;
    assign bus_if.o_bus_write = wr_q;
    assign bus_if.o_bus_wsel  = wsel_q;
    assign bus_if.o_bus_wdata = wdata_q;
    assign bus_if.o_ins_ack   = ins_ack_q;
    assign bus_if.o_ins_err   = ins_err_q;
    assign bus_if.o_ins_data  = ins_data_q;
    assign bus_if.o_dat_ack   = dat_ack_q;
    assign bus_if.o_dat_err   = dat_err_q;
    assign bus_if.o_dat_data  = dat_data_q;

`ifdef RV_CACHE_ARB_PERF_EN
    logic [31:0] perf_ins_q, perf_dat_q, perf_conf_q, perf_tmo_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_ins_q  <= '0;
            perf_dat_q  <= '0;
            perf_conf_q <= '0;
            perf_tmo_q  <= '0;
        end else begin
            if (state_q == IDLE && req != 2'b00) begin
                if (grant == PORT_INS) perf_ins_q <= perf_ins_q + 32'd1;
                else                   perf_dat_q <= perf_dat_q + 32'd1;
                if (req == 2'b11)      perf_conf_q <= perf_conf_q + 32'd1;
            end
            if (timeout) perf_tmo_q <= perf_tmo_q + 32'd1;
        end
    end

    assign o_perf_ins_grants = perf_ins_q;
    assign o_perf_dat_grants = perf_dat_q;
    assign o_perf_conflicts  = perf_conf_q;
    assign o_perf_timeouts   = perf_tmo_q;
`endif

endmodule

// File: tb/tb_rv_cache_bus_arb.sv
// tb/tb_rv_cache_bus_arb.sv - self-checking bench for rv_cache_bus_arb with a transaction-level model
module tb_rv_cache_bus_arb;
    import rv_cache_arb_pkg::*;

    localparam int TB  = 4;
    localparam int TMO = (1 << TB) - 1;

    typedef struct {
        int          port;
        int          cyc;
        logic [31:0] data;
        logic        err;
    } comp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rv_cache_bus_arb_if bif ();

`ifdef RV_CACHE_ARB_PERF_EN
    logic [31:0] p_ig, p_dg, p_cf, p_to;
`endif

    rv_cache_bus_arb #(.PRIO_DATA(1), .TIMEOUT_BIT(TB)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus_if    (bif)
`ifdef RV_CACHE_ARB_PERF_EN
        ,
        .o_perf_ins_grants (p_ig),
        .o_perf_dat_grants (p_dg),
        .o_perf_conflicts  (p_cf),
        .o_perf_timeouts   (p_to)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          m_phase = 0;   // 0 free, 1 bus owned, 2 completion cycle
    int          m_owner = 0;   // 0 instr, 1 data
    int          m_last  = 0;
    int          m_wait  = 0;   // bus cycles elapsed without an ack
    logic        e_rd = 0, e_wr = 0;
    logic [31:0] e_addr = 0, e_wdata = 0;
    logic [3:0]  e_wsel = 0;
    logic        e_iack = 0, e_dack = 0, e_ierr = 0, e_derr = 0;
    logic [31:0] e_idata = 0, e_ddata = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit ri, rdq;
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_last = 0; m_wait = 0;
            e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_wsel = 0;
            e_iack = 0; e_dack = 0; e_ierr = 0; e_derr = 0; e_idata = 0; e_ddata = 0;
        end else begin
            e_iack = 0; e_dack = 0; e_ierr = 0; e_derr = 0; e_idata = 0; e_ddata = 0;
            if (m_phase == 0) begin
                ri  = bif.i_ins_read;
                rdq = bif.i_dat_read | bif.i_dat_write;
                if (ri || rdq) begin
                    m_owner = (ri && rdq) ? 1 - m_last : (rdq ? 1 : 0);
                    m_last  = m_owner;
                    m_phase = 1;
                    m_wait  = 0;
                    if (m_owner == 0) begin
                        e_rd = 1; e_wr = 0; e_addr = bif.i_ins_addr; e_wsel = 4'hF; e_wdata = 0;
                    end else begin
                        e_rd = bif.i_dat_read; e_wr = bif.i_dat_write; e_addr = bif.i_dat_addr;
                        e_wsel  = bif.i_dat_write ? bif.i_dat_wsel : 4'hF;
                        e_wdata = bif.i_dat_write ? bif.i_dat_wdata : 32'h0;
                    end
                end
            end else if (m_phase == 1) begin
                if (bif.i_bus_ack || m_wait + 1 == TMO) begin
                    if (m_owner == 0) begin
                        e_iack = 1; e_ierr = !bif.i_bus_ack;
                        e_idata = bif.i_bus_ack ? bif.i_bus_data : 32'h0;
                    end else begin
                        e_dack = 1; e_derr = !bif.i_bus_ack;
                        e_ddata = (bif.i_bus_ack && !e_wr) ? bif.i_bus_data : 32'h0;
                    end
                    e_rd = 0; e_wr = 0;
                    m_phase = 2;
                end else begin
                    m_wait++;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        if (rst_n) begin
            chk("bus_read", bif.o_bus_read, e_rd);
            chk("bus_write", bif.o_bus_write, e_wr);
            if (e_rd || e_wr) begin
                chk("bus_addr", bif.o_bus_addr, e_addr);
                chk("bus_wsel", bif.o_bus_wsel, e_wsel);
            end
            if (e_wr) chk("bus_wdata", bif.o_bus_wdata, e_wdata);
            chk("ins_ack", bif.o_ins_ack, e_iack);
            chk("dat_ack", bif.o_dat_ack, e_dack);
            chk("ins_err", bif.o_ins_err, e_ierr);
            chk("dat_err", bif.o_dat_err, e_derr);
            if (e_iack) chk("ins_data", bif.o_ins_data, e_idata);
            if (e_dack) chk("dat_data", bif.o_dat_data, e_ddata);
        end
    end

    // ---------------- bus responder ----------------
    bit          resp_rand = 0;
    int          resp_lat  = 2;      // -1: never ack
    logic [31:0] resp_data = 32'hDEAD_BEEF;
    int          bcnt = 0, cur_lat = 0, last_len = 0;
    logic [31:0] cap_addr = 0, cap_wdata = 0;
    logic [3:0]  cap_wsel = 0;
    logic        cap_wr = 0;

    always @(negedge clk) begin : responder
        int r;
        #1;
        if (bif.o_bus_read || bif.o_bus_write) begin
            bcnt++;
            if (bcnt == 1) begin
                cap_addr = bif.o_bus_addr; cap_wsel = bif.o_bus_wsel;
                cap_wdata = bif.o_bus_wdata; cap_wr = bif.o_bus_write;
                r = $urandom_range(15);
                cur_lat = (r < 10) ? r % 4 : (r < 12) ? 13 : (r < 14) ? 14 : 20;
            end
        end else begin
            if (bcnt > 0) last_len = bcnt;
            bcnt = 0;
        end
        if (resp_rand) begin
            bif.i_bus_ack  = (bcnt == 0) ? ($urandom_range(3) == 0) : (bcnt == cur_lat + 1);
            bif.i_bus_data = $urandom;
        end else begin
            bif.i_bus_ack  = (resp_lat >= 0 && bcnt == resp_lat + 1);
            bif.i_bus_data = resp_data;
        end
    end

    // ---------------- requesters ----------------
    bit          ins_auto = 0, dat_auto = 0, ins_always = 0, dat_always = 0, ins_go = 0, dat_go = 0;
    logic [31:0] go_ins_addr = 0, go_dat_addr = 0, go_dat_wdata = 0;
    logic [3:0]  go_dat_wsel = 0;
    bit          go_dat_wr = 0;
    int          req_cyc_i = 0, req_cyc_d = 0;
    comp_t       comps[$];

    always @(negedge clk) begin : req_gen
        comp_t c;
        bit    w;
        #1;
        cyc++;
        if (bif.i_ins_read) begin
            if (bif.o_ins_ack) begin
                bif.i_ins_read = 1'b0;
                c.port = 0; c.cyc = cyc; c.data = bif.o_ins_data; c.err = bif.o_ins_err;
                comps.push_back(c);
            end else if (ins_auto) bif.i_ins_addr = $urandom;
        end else if (ins_go || ins_always || (ins_auto && $urandom_range(2) == 0)) begin
            bif.i_ins_read = 1'b1;
            bif.i_ins_addr = ins_go ? go_ins_addr : $urandom;
            ins_go = 0; req_cyc_i = cyc;
        end
        if (bif.i_dat_read || bif.i_dat_write) begin
            if (bif.o_dat_ack) begin
                bif.i_dat_read = 1'b0; bif.i_dat_write = 1'b0;
                c.port = 1; c.cyc = cyc; c.data = bif.o_dat_data; c.err = bif.o_dat_err;
                comps.push_back(c);
            end else if (dat_auto) begin
                bif.i_dat_addr = $urandom; bif.i_dat_wsel = 4'($urandom); bif.i_dat_wdata = $urandom;
            end
        end else if (dat_go || dat_always || (dat_auto && $urandom_range(2) == 0)) begin
            w = dat_go ? go_dat_wr : 1'($urandom_range(1));
            bif.i_dat_read  = !w;
            bif.i_dat_write = w;
            bif.i_dat_addr  = dat_go ? go_dat_addr  : $urandom;
            bif.i_dat_wsel  = dat_go ? go_dat_wsel  : 4'($urandom);
            bif.i_dat_wdata = dat_go ? go_dat_wdata : $urandom;
            dat_go = 0; req_cyc_d = cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_comps(input int n, input int budget, input string nm);
        int k = 0;
        while (comps.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (comps.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d completions, required %0d", nm, comps.size(), n);
        end
    endtask

    function automatic comp_t pop_comp();
        comp_t c;
        c.port = -1; c.cyc = -1; c.data = 32'hX; c.err = 1'bX;
        if (comps.size() > 0) c = comps.pop_front();
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        comps.delete();
    endtask

    task automatic drain(input int budget, input string nm);
        int k = 0;
        while ((bif.i_ins_read || bif.i_dat_read || bif.i_dat_write) && k < budget) begin
            step();
            k++;
        end
        chk(nm, 32'(bif.i_ins_read | bif.i_dat_read | bif.i_dat_write), 32'h0);
        comps.delete();
    endtask

    initial begin : main
        comp_t c, c1;
        int    nd;
        bif.i_ins_read = 0; bif.i_ins_addr = 0;
        bif.i_dat_read = 0; bif.i_dat_write = 0; bif.i_dat_addr = 0;
        bif.i_dat_wsel = 0; bif.i_dat_wdata = 0;
        bif.i_bus_ack = 0; bif.i_bus_data = 0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bus_read", bif.o_bus_read, 0);
        chk("rst_bus_write", bif.o_bus_write, 0);
        chk("rst_bus_addr", bif.o_bus_addr, 0);
        chk("rst_bus_wsel", bif.o_bus_wsel, 0);
        chk("rst_bus_wdata", bif.o_bus_wdata, 0);
        chk("rst_ins_ack", bif.o_ins_ack, 0);
        chk("rst_dat_ack", bif.o_dat_ack, 0);
        chk("rst_ins_err", bif.o_ins_err, 0);
        chk("rst_dat_err", bif.o_dat_err, 0);
        chk("rst_ins_data", bif.o_ins_data, 0);
        chk("rst_dat_data", bif.o_dat_data, 0);
        #3 rst_n = 1'b1;

        // single instr read, ack two cycles after the strobe
        resp_lat = 2; resp_data = 32'hDEAD_BEEF; go_ins_addr = 32'h0000_0100; ins_go = 1;
        wait_comps(1, 30, "t1_wait");
        c = pop_comp();
        chk("t1_port", c.port, 0);
        chk("t1_data", c.data, 32'hDEAD_BEEF);
        chk("t1_err", c.err, 0);
        chk("t1_latency", c.cyc - req_cyc_i, 4);
        chk("t1_addr", cap_addr, 32'h0000_0100);
        chk("t1_strobe_len", last_len, 3);

        // minimum latency: same-cycle bus ack
        resp_lat = 0; resp_data = 32'h0BAD_F00D; go_ins_addr = 32'h0000_0200; ins_go = 1;
        wait_comps(1, 30, "t1b_wait");
        c = pop_comp();
        chk("t1b_latency", c.cyc - req_cyc_i, 2);
        chk("t1b_data", c.data, 32'h0BAD_F00D);

        // simultaneous requests from reset: data first
        do_reset();
        resp_lat = 1; resp_data = 32'h1111_2222;
        go_ins_addr = 32'h0000_0300; go_dat_addr = 32'h0000_0400; go_dat_wr = 0; go_dat_wsel = 4'h5;
        ins_go = 1; dat_go = 1;
        wait_comps(2, 40, "t2_wait");
        c = pop_comp(); c1 = pop_comp();
        chk("t2_first_port", c.port, 1);
        chk("t2_second_port", c1.port, 0);
        chk("t2_distinct_cycle", 32'(c.cyc != c1.cyc), 1);
        chk("t2_one_each", comps.size(), 0);

        // data write
        resp_lat = 1; resp_data = 32'hCAFE_F00D;
        go_dat_wr = 1; go_dat_addr = 32'h0000_0040; go_dat_wsel = 4'b0011; go_dat_wdata = 32'h1234_5678;
        dat_go = 1;
        wait_comps(1, 30, "t3_wait");
        c = pop_comp();
        chk("t3_bus_write", cap_wr, 1);
        chk("t3_bus_wsel", cap_wsel, 4'b0011);
        chk("t3_bus_wdata", cap_wdata, 32'h1234_5678);
        chk("t3_dat_data", c.data, 0);
        chk("t3_err", c.err, 0);

        // bus never acks: timeout after 15 wait cycles, then normal service
        resp_lat = -1; go_ins_addr = 32'h0000_0500; ins_go = 1;
        wait_comps(1, 60, "t4_wait");
        c = pop_comp();
        chk("t4_err", c.err, 1);
        chk("t4_data", c.data, 0);
        chk("t4_wait_cycles", last_len, TMO);
        resp_lat = 1; resp_data = 32'h5555_AAAA; go_ins_addr = 32'h0000_0600; ins_go = 1;
        wait_comps(1, 30, "t4b_wait");
        c = pop_comp();
        chk("t4b_err", c.err, 0);
        chk("t4b_data", c.data, 32'h5555_AAAA);

        // asynchronous reset while the data port owns the bus
        resp_lat = -1; go_dat_wr = 0; go_dat_addr = 32'h0000_0700; dat_go = 1;
        nd = 0;
        while (!bif.o_bus_read && nd < 20) begin step(); nd++; end
        chk("t5_bus_read_up", bif.o_bus_read, 1);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_read", bif.o_bus_read, 0);
        chk("t5_async_write", bif.o_bus_write, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        chk("t5_no_ack", comps.size(), 0);
        resp_lat = 1; resp_data = 32'h7777_8888;
        wait_comps(1, 30, "t5_regrant_wait");
        c = pop_comp();
        chk("t5_regrant_port", c.port, 1);
        chk("t5_regrant_err", c.err, 0);
        chk("t5_regrant_data", c.data, 32'h7777_8888);

        // continuous data requests with instr pending: strict alternation
        resp_lat = 0;
        ins_always = 1; dat_always = 1;
        wait_comps(8, 120, "t6_wait");
        ins_always = 0; dat_always = 0;
        c = pop_comp();
        nd = (c.port == 1) ? 1 : 0;
        for (int i = 1; i < 8; i++) begin
            c1 = pop_comp();
            chk("t6_alternate", 32'(c1.port != c.port), 1);
            if (c1.port == 1) nd++;
            c = c1;
        end
        chk("t6_dat_count", nd, 4);
        drain(40, "t6_drain");

        // randomized traffic against the model
        resp_rand = 1; ins_auto = 1; dat_auto = 1;
        repeat (3000) step();
        ins_auto = 0; dat_auto = 0;
        drain(200, "rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
